// File: rtl/pc_ras_ctrl_pkg.sv
// Shared constants and request encoding for the fetch-stage PC / return-address stack.
// Decode and pc_ras_ctrl both use these so the two sides agree on request priority.
package pc_ras_ctrl_pkg;

  localparam int PC_W_DEF  = 7;
  localparam int DEPTH_DEF = 4;
  localparam int RESET_PC  = 0;

  typedef enum logic [1:0] {
    REQ_SEQ  = 2'd0,
    REQ_BR   = 2'd1,
    REQ_CALL = 2'd2,
    REQ_RET  = 2'd3
  } req_e;

  // Resolve simultaneous requests: return beats call, call beats branch.
  function automatic req_e decode_req(input logic ret_en, input logic call_en,
                                      input logic branch_en);
    if (ret_en)         return REQ_RET;
    else if (call_en)   return REQ_CALL;
    else if (branch_en) return REQ_BR;
    else                return REQ_SEQ;
  endfunction

endpackage

// File: rtl/pc_ras_ctrl_ras_stack.sv
// Circular return-address stack: when full, a push overwrites the oldest entry.
// Overflow and underflow are single-cycle pulses; the sticky flag lives in the parent.
module ras_stack
  import pc_ras_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_data,
  output logic [PC_W-1:0]  top_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ptr_q is the next free slot; the top entry sits one below it.
  assign top_data  = mem[ptr_q - PTR_W'(1)];
  assign count     = cnt_q;
  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can form.
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: state flops take non-blocking assignments so all see pre-edge values.
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: entries are never reset; cnt_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_ras_ctrl.sv
// Fetch PC register with sequential/branch/call/return selection feeding a return-address stack.
// Holds the +1 incrementer, the priority mux and the sticky stack-error flag.
module pc_ras_ctrl
  import pc_ras_ctrl_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             call_en,
  input  logic [PC_W-1:0]  call_target,
  input  logic             ret_en,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ras_top;
  logic            err_q, err_d;
  logic            push, pop, overflow, underflow;
  req_e            req;

  ras_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  assign pc_inc = pc_q + PC_W'(1);
  assign req    = decode_req(ret_en, call_en, branch_en);

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    if (!stall) begin
      unique case (req)
        // An empty-stack return degrades to a sequential step.
        REQ_RET: begin
          pop  = 1'b1;
          pc_d = ras_empty ? pc_inc : ras_top;
        end
        REQ_CALL: begin
          push = 1'b1;
          pc_d = call_target;
        end
        REQ_BR:  pc_d = branch_target;
        default: pc_d = pc_inc;
      endcase
    end
    err_d = err_q | overflow | underflow;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= PC_W'(RESET_PC);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc      = pc_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_pc_ras_ctrl.sv
// Self-checking bench: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_pc_ras_ctrl;

  localparam int PC_W  = 7;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PC_M  = 1 << PC_W;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             branch_en;
  logic [PC_W-1:0]  branch_target;
  logic             call_en;
  logic [PC_W-1:0]  call_target;
  logic             ret_en;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  pc_ras_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .call_en       (call_en),
    .call_target   (call_target),
    .ret_en        (ret_en),
    .pc            (pc),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_err       (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: the stack is a queue, newest entry at the back.
  int m_pc  = 0;
  int m_err = 0;
  int m_ras[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc  = 0;
      m_err = 0;
      m_ras.delete();
    end else if (!stall) begin
      if (ret_en) begin
        if (m_ras.size() == 0) begin
          m_err = 1;
          m_pc  = (m_pc + 1) % PC_M;
        end else begin
          m_pc = m_ras.pop_back();
        end
      end else if (call_en) begin
        m_ras.push_back((m_pc + 1) % PC_M);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1;
        end
        m_pc = int'(call_target);
      end else if (branch_en) begin
        m_pc = int'(branch_target);
      end else begin
        m_pc = (m_pc + 1) % PC_M;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc",    int'(pc),        m_pc);
      check("model_count", int'(ras_count), m_ras.size());
      check("model_empty", int'(ras_empty), int'(m_ras.size() == 0));
      check("model_full",  int'(ras_full),  int'(m_ras.size() == DEPTH));
      check("model_err",   int'(ras_err),   m_err);
    end
  end

  // Drive one cycle of requests, then return just after the edge that consumes them.
  task automatic cyc(input logic s, input logic b, input int bt,
                     input logic c, input int ct, input logic r);
    stall         = s;
    branch_en     = b;
    branch_target = PC_W'(bt);
    call_en       = c;
    call_target   = PC_W'(ct);
    ret_en        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic branch(input int t);
    cyc(1'b0, 1'b1, t, 1'b0, 0, 1'b0);
  endtask

  task automatic call(input int t);
    cyc(1'b0, 1'b0, 0, 1'b1, t, 1'b0);
  endtask

  task automatic ret();
    cyc(1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    chk_en = 1'b1;
    idle();
    rst_n = 1'b1;
    check("rst_pc",    int'(pc), 0);
    check("rst_count", int'(ras_count), 0);
    check("rst_empty", int'(ras_empty), 1);
    check("rst_err",   int'(ras_err), 0);

    // Free-running sequential fetch wraps at 2^PC_W.
    for (int i = 1; i <= 130; i++) begin
      idle();
      if (i == 127) check("seq_127", int'(pc), 127);
      if (i == 128) check("seq_wrap", int'(pc), 0);
    end
    check("seq_end_pc",  int'(pc), 2);
    check("seq_empty",   int'(ras_empty), 1);
    check("seq_err",     int'(ras_err), 0);

    // Single call/return pair.
    branch(10);
    call(40);
    check("call_pc",    int'(pc), 40);
    check("call_count", int'(ras_count), 1);
    ret();
    check("ret_pc",     int'(pc), 11);
    check("ret_count",  int'(ras_count), 0);

    // Nested calls: pushes 6, 23, 52.
    branch(5);
    call(20);
    idle();
    idle();
    call(50);
    idle();
    call(70);
    ret();
    check("nest_ret1", int'(pc), 52);
    ret();
    check("nest_ret2", int'(pc), 23);
    ret();
    check("nest_ret3", int'(pc), 6);
    check("nest_empty", int'(ras_empty), 1);

    // Overflow: five calls into a 4-deep stack, then five returns.
    for (int k = 0; k < 5; k++) begin
      branch(10 * k + 1);
      call(10 * k + 10);
      if (k == 3) begin
        check("ovf_full_before", int'(ras_full), 1);
        check("ovf_err_before",  int'(ras_err), 0);
      end
    end
    check("ovf_err",   int'(ras_err), 1);
    check("ovf_count", int'(ras_count), 4);
    ret();
    check("ovf_ret1", int'(pc), 42);
    ret();
    check("ovf_ret2", int'(pc), 32);
    ret();
    check("ovf_ret3", int'(pc), 22);
    ret();
    check("ovf_ret4", int'(pc), 12);
    ret();
    check("unf_pc",    int'(pc), 13);
    check("unf_count", int'(ras_count), 0);
    check("unf_err",   int'(ras_err), 1);

    // Priority: return wins over call and branch; stalled call is ignored.
    branch(32);
    call(60);
    cyc(1'b0, 1'b1, 77, 1'b1, 99, 1'b1);
    check("prio_pc",    int'(pc), 33);
    check("prio_count", int'(ras_count), 0);
    cyc(1'b1, 1'b0, 0, 1'b1, 99, 1'b0);
    check("stall_pc",    int'(pc), 33);
    check("stall_count", int'(ras_count), 0);

    // Reset in the middle of a call discards everything.
    call(1);
    call(2);
    call(3);
    check("pre_rst_count", int'(ras_count), 3);
    check("pre_rst_err",   int'(ras_err), 1);
    rst_n = 1'b0;
    call(4);
    rst_n = 1'b1;
    check("mid_rst_pc",    int'(pc), 0);
    check("mid_rst_count", int'(ras_count), 0);
    check("mid_rst_err",   int'(ras_err), 0);
    check("mid_rst_empty", int'(ras_empty), 1);

    // Randomized soak, checked every cycle by the model comparison.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(logic'($urandom_range(0, 7) == 0),
          logic'($urandom_range(0, 2) == 0), int'($urandom_range(0, PC_M - 1)),
          logic'($urandom_range(0, 2) == 0), int'($urandom_range(0, PC_M - 1)),
          logic'($urandom_range(0, 2) == 0));
    end
    rst_n = 1'b1;
    idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
